// File: rtl/simd_enable_stack.sv
// Per-lane SIMD enable-mask stack: ALLEN/PUSHEN/POPEN/JUMPF ops, depth tracking, sticky overflow/underflow.
// Defining ENSTACK_ELSE_EN enables op 5 (ELSEN); otherwise op 5 is reserved.
module simd_enable_stack #(
  parameter int NPE   = 4,
  parameter int DEPTH = 32,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           op_valid,
  input  logic [2:0]     op,
  input  logic [NPE-1:0] cond_zero,
  input  logic           err_clr,
  output logic [NPE-1:0] en,
  output logic           any_en,
  output logic [DW-1:0]  depth,
  output logic           overflow,
  output logic           underflow
);

  localparam logic [2:0] OpAllen  = 3'd1;
  localparam logic [2:0] OpPushen = 3'd2;
  localparam logic [2:0] OpPopen  = 3'd3;
  localparam logic [2:0] OpJumpf  = 3'd4;
`ifdef ENSTACK_ELSE_EN
  localparam logic [2:0] OpElsen  = 3'd5;
`endif

  localparam logic [DW-1:0] MaxDepth = DW'(DEPTH - 1);

  // Bit 0 of each lane vector is the top of that lane's stack.
  logic [NPE-1:0][DEPTH-1:0] stack_q, stack_d;
  logic [DW-1:0]             depth_q, depth_d;
  logic                      overflow_q, overflow_d;
  logic                      underflow_q, underflow_d;

  always_comb begin
    stack_d     = stack_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q & ~err_clr;
    underflow_d = underflow_q & ~err_clr;
    if (op_valid) begin
      case (op)
        OpAllen: begin
          for (int i = 0; i < NPE; i++) stack_d[i][0] = 1'b1;
        end
        OpPushen: begin
          for (int i = 0; i < NPE; i++) stack_d[i] = {stack_q[i][DEPTH-2:0], stack_q[i][0]};
          if (depth_q == MaxDepth) overflow_d = 1'b1;
          else                     depth_d    = depth_q + DW'(1);
        end
        OpPopen: begin
          for (int i = 0; i < NPE; i++) stack_d[i] = {1'b1, stack_q[i][DEPTH-1:1]};
          if (depth_q == '0) underflow_d = 1'b1;
          else               depth_d     = depth_q - DW'(1);
        end
        OpJumpf: begin
          for (int i = 0; i < NPE; i++) stack_d[i][0] = stack_q[i][0] & ~cond_zero[i];
        end
`ifdef ENSTACK_ELSE_EN
        // At base depth there is no enclosing level, so the outer mask counts as enabled.
        OpElsen: begin
          for (int i = 0; i < NPE; i++)
            stack_d[i][0] = ~stack_q[i][0] & ((depth_q == '0) ? 1'b1 : stack_q[i][1]);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stack_q     <= '1;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      stack_q     <= stack_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    en = '0;
    for (int i = 0; i < NPE; i++) en[i] = stack_q[i][0];
  end

  assign any_en    = |en;
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_simd_enable_stack.sv
// Scoreboard bench for simd_enable_stack (NPE=4, DEPTH=4): queue-of-masks reference model, directed then random ops.
module tb_simd_enable_stack;

  localparam int NPE   = 4;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           op_valid = 1'b0;
  logic [2:0]     op = 3'd0;
  logic [NPE-1:0] cond_zero = '0;
  logic           err_clr = 1'b0;
  logic [NPE-1:0] en;
  logic           any_en;
  logic [DW-1:0]  depth;
  logic           overflow;
  logic           underflow;

  simd_enable_stack #(.NPE(NPE), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .cond_zero(cond_zero), .err_clr(err_clr), .en(en), .any_en(any_en),
    .depth(depth), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NPE-1:0] en;
    logic           anyEn;
    logic [DW-1:0]  depth;
    logic           ovf;
    logic           unf;
    string          name;
  } exp_t;

  exp_t expQ[$];
  int checkCount = 0;
  int passCount  = 0;

  // Reference model: a list of whole-lane masks, element 0 being the top level.
  logic [NPE-1:0] mq[$];
  int             mDepth;
  logic           mOvf, mUnf;

  task automatic modelReset();
    mq.delete();
    for (int k = 0; k < DEPTH; k++) mq.push_back('1);
    mDepth = 0;
    mOvf   = 1'b0;
    mUnf   = 1'b0;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [2:0] o,
                               input logic [NPE-1:0] cz, input logic clr, input string name);
    exp_t e;
    logic [NPE-1:0] top, outer;
    @(negedge clk);
    reset = r; op_valid = v; op = o; cond_zero = cz; err_clr = clr;
    if (r) modelReset();
    else begin
      if (clr) begin mOvf = 1'b0; mUnf = 1'b0; end
      if (v) begin
        case (o)
          3'd1: mq[0] = '1;
          3'd2: begin
            mq.push_front(mq[0]);
            void'(mq.pop_back());
            if (mDepth < DEPTH - 1) mDepth++; else mOvf = 1'b1;
          end
          3'd3: begin
            void'(mq.pop_front());
            mq.push_back('1);
            if (mDepth > 0) mDepth--; else mUnf = 1'b1;
          end
          3'd4: mq[0] = mq[0] & ~cz;
          3'd5: begin
`ifdef ENSTACK_ELSE_EN
            top   = mq[0];
            outer = (mDepth == 0) ? '1 : mq[1];
            mq[0] = ~top & outer;
`else
            top = '0; outer = '0;
`endif
          end
          default: ;
        endcase
      end
    end
    e.en = mq[0]; e.anyEn = (mq[0] != '0); e.depth = DW'(mDepth);
    e.ovf = mOvf; e.unf = mUnf; e.name = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s got=%0h exp=%0h", name, got, want);
  endtask

  // Monitor: each posedge presents the result of the op driven at the preceding negedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.name, ".en"},    8'(en),        8'(e.en));
        checkOutput({e.name, ".any"},   8'(any_en),    8'(e.anyEn));
        checkOutput({e.name, ".depth"}, 8'(depth),     8'(e.depth));
        checkOutput({e.name, ".ovf"},   8'(overflow),  8'(e.ovf));
        checkOutput({e.name, ".unf"},   8'(underflow), 8'(e.unf));
      end
    end
  end

  initial begin
    int waitCycles;
    modelReset();
    applyStimulus(1, 0, 3'd0, 4'b0000, 0, "reset");
    applyStimulus(0, 1, 3'd2, 4'b0000, 0, "push1");
    applyStimulus(0, 1, 3'd4, 4'b0101, 0, "jumpf0101");
    applyStimulus(0, 1, 3'd3, 4'b0000, 0, "pop1");
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 3'd2, 4'b0000, 0, "pushFill");
    applyStimulus(0, 1, 3'd2, 4'b0000, 0, "pushOvf");
    applyStimulus(0, 1, 3'd2, 4'b0000, 1, "pushOvfClr");
    applyStimulus(0, 0, 3'd0, 4'b0000, 1, "clrOvf");
    applyStimulus(1, 0, 3'd0, 4'b0000, 0, "reset2");
    applyStimulus(0, 1, 3'd3, 4'b0000, 0, "popUnf");
    applyStimulus(0, 1, 3'd4, 4'b1111, 0, "jumpfAll");
    applyStimulus(0, 1, 3'd1, 4'b0000, 0, "allen");
    applyStimulus(0, 0, 3'd2, 4'b0000, 0, "invalidPush");
    applyStimulus(0, 1, 3'd2, 4'b0000, 0, "pushA");
    applyStimulus(0, 1, 3'd2, 4'b0000, 0, "pushB");
    applyStimulus(0, 1, 3'd4, 4'b1100, 0, "jumpf1100");
    applyStimulus(1, 1, 3'd2, 4'b0000, 1, "resetMid");
    applyStimulus(0, 1, 3'd2, 4'b0000, 0, "elsePush");
    applyStimulus(0, 1, 3'd4, 4'b0011, 0, "elseJumpf");
    applyStimulus(0, 1, 3'd5, 4'b0000, 0, "elsen");
    applyStimulus(0, 1, 3'd3, 4'b0000, 0, "elsePop");
    applyStimulus(0, 1, 3'd5, 4'b0000, 0, "elsenBase");
    applyStimulus(0, 1, 3'd6, 4'b1111, 0, "op6");
    applyStimulus(0, 1, 3'd7, 4'b1111, 0, "op7");
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 8),
                    3'($urandom_range(0, 7)), 4'($urandom), ($urandom_range(0, 9) == 0), "rand");
    end
    @(negedge clk);
    op_valid = 1'b0; reset = 1'b0; err_clr = 1'b0;
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      checkCount++;
      $display("[TB] FAIL drain got=%0d pending exp=0", expQ.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
